// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, the NOP encoding, pipe FSM states
// and operand-usage helpers used by the load-use interlock.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    localparam logic [31:0] NOP_INSN = 32'h6800_0000;
    localparam logic [3:0]  RA_REG   = 4'd15;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } pipe_state_t;

    function automatic logic reads_rs1(input logic [4:0] op);
        return !(op == OP_NOP || op == OP_B || op == OP_CALL ||
                 op == OP_RET || op == OP_MOV || op == OP_NOT);
    endfunction

    // Register-form ALU ops (add..asr, including cmp/not/mov) take rs2.
    function automatic logic reads_rs2(input logic [4:0] op, input logic imm);
        return !imm && (op <= OP_ASR);
    endfunction

    function automatic logic reads_rd(input logic [4:0] op);
        return op == OP_ST;
    endfunction

endpackage

// File: rtl/of_ex_pipe_reg_load_use_detect.sv
// Combinational load-use detector: a valid load in EX whose destination is
// read as a source by the instruction currently in OF.
module load_use_detect
    import simplerisc_pkg::*;
(
    input  logic       valid_e,
    input  logic [4:0] op_e,
    input  logic [3:0] rd_e,
    input  logic [4:0] op_of,
    input  logic       imm_of,
    input  logic [3:0] rd_of,
    input  logic [3:0] rs1_of,
    input  logic [3:0] rs2_of,
    output logic       lu
);

    logic src_hit;

    always_comb begin
        src_hit = 1'b0;
        if (reads_rs1(op_of) && rs1_of == rd_e)
            src_hit = 1'b1;
        if (reads_rs2(op_of, imm_of) && rs2_of == rd_e)
            src_hit = 1'b1;
        if (reads_rd(op_of) && rd_of == rd_e)
            src_hit = 1'b1;
        // ret implicitly reads the return-address register
        if (op_of == OP_RET && rd_e == RA_REG)
            src_hit = 1'b1;
        lu = valid_e && (op_e == OP_LD) && src_hit;
    end

endmodule

// File: rtl/of_ex_pipe_reg.sv
// OF->EX pipeline latch with a one-bubble load-use interlock, branch flush
// and a saturating stall-cycle counter.
module of_ex_pipe_reg
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 22,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction_of,
    input  logic [DATA_W-1:0] pc_of,
    input  logic [DATA_W-1:0] op1_of,
    input  logic [DATA_W-1:0] op2_of,
    input  logic [DATA_W-1:0] immx_of,
    input  logic [CTRL_W-1:0] ctrl_of,
    input  logic              isBranchTaken,
    output logic [31:0]       instruction_e,
    output logic [DATA_W-1:0] pc_e,
    output logic [DATA_W-1:0] op1_e,
    output logic [DATA_W-1:0] op2_e,
    output logic [DATA_W-1:0] immx_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              valid_e,
    output logic              stall_if,
    output logic [CNT_W-1:0]  stall_count,
    output pipe_state_t       fsm_state
);

    logic lu;

    load_use_detect u_lu (
        .valid_e (valid_e),
        .op_e    (instruction_e[31:27]),
        .rd_e    (instruction_e[25:22]),
        .op_of   (instruction_of[31:27]),
        .imm_of  (instruction_of[26]),
        .rd_of   (instruction_of[25:22]),
        .rs1_of  (instruction_of[21:18]),
        .rs2_of  (instruction_of[17:14]),
        .lu      (lu)
    );

    // A flush wins over the interlock: the consumer is squashed anyway.
    assign stall_if = !rst && (fsm_state == ST_RUN) && lu && !isBranchTaken;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state     <= ST_RUN;
            instruction_e <= NOP_INSN;
            pc_e          <= '0;
            op1_e         <= '0;
            op2_e         <= '0;
            immx_e        <= '0;
            ctrl_e        <= '0;
            valid_e       <= 1'b0;
            stall_count   <= '0;
        end else begin
            case (fsm_state)
                ST_RUN:   fsm_state <= stall_if ? ST_STALL : ST_RUN;
                ST_STALL: fsm_state <= ST_RUN;
                default:  fsm_state <= ST_RUN;
            endcase

            if (isBranchTaken || stall_if) begin
                // Bubble: data fields keep stale values, only identity is cleared.
                instruction_e <= NOP_INSN;
                ctrl_e        <= '0;
                valid_e       <= 1'b0;
            end else begin
                instruction_e <= instruction_of;
                pc_e          <= pc_of;
                op1_e         <= op1_of;
                op2_e         <= op2_of;
                immx_e        <= immx_of;
                ctrl_e        <= ctrl_of;
                valid_e       <= 1'b1;
            end

            if (stall_if && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_of_ex_pipe_reg.sv
// Bench for of_ex_pipe_reg: directed vector table, reset/saturation sequences
// and randomized traffic against a behavioural pipeline model.
module tb_of_ex_pipe_reg;
    import simplerisc_pkg::*;

    localparam int TB_CNT_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instruction_of;
    logic [31:0]       pc_of, op1_of, op2_of, immx_of;
    logic [21:0]       ctrl_of;
    logic              isBranchTaken;
    logic [31:0]       instruction_e;
    logic [31:0]       pc_e, op1_e, op2_e, immx_e;
    logic [21:0]       ctrl_e;
    logic              valid_e;
    logic              stall_if;
    logic [TB_CNT_W-1:0] stall_count;
    pipe_state_t       fsm_state;

    of_ex_pipe_reg #(.DATA_W(32), .CTRL_W(22), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .instruction_of(instruction_of), .pc_of(pc_of), .op1_of(op1_of),
        .op2_of(op2_of), .immx_of(immx_of), .ctrl_of(ctrl_of),
        .isBranchTaken(isBranchTaken),
        .instruction_e(instruction_e), .pc_e(pc_e), .op1_e(op1_e),
        .op2_e(op2_e), .immx_e(immx_e), .ctrl_e(ctrl_e), .valid_e(valid_e),
        .stall_if(stall_if), .stall_count(stall_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input bit i, input int rd,
                                        input int rs1, input logic [17:0] low);
        return {5'(op), i, 4'(rd), 4'(rs1), low};
    endfunction

    // Behavioural model: what EX should hold, plus stall bookkeeping.
    logic [31:0] m_insn, m_pc, m_op1, m_op2, m_imm;
    logic [21:0] m_ctrl;
    bit          m_valid, m_in_stall;
    int          m_cnt;
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    // Source registers named by the instruction, built as a list.
    function automatic bit m_reads(input logic [31:0] insn, input logic [3:0] r);
        int op;
        logic [3:0] srcs[$];
        op = int'(insn[31:27]);
        if (!(op inside {13, 18, 19, 20, 9, 8})) srcs.push_back(insn[21:18]);
        if (!insn[26] && op <= 12) srcs.push_back(insn[17:14]);
        if (op == 15) srcs.push_back(insn[25:22]);
        if (op == 20) srcs.push_back(4'd15);
        foreach (srcs[k]) if (srcs[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_lu(input logic [31:0] insn, input bit bt, input bit rst_v);
        if (rst_v || bt || m_in_stall || !m_valid) return 1'b0;
        if (m_insn[31:27] != 5'd14) return 1'b0;
        return m_reads(insn, m_insn[25:22]);
    endfunction

    task automatic step(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] o1,
                        input logic [31:0] o2, input logic [31:0] im, input logic [21:0] ct,
                        input bit bt, input bit rst_v, output bit act_stall, output bit exp_stall);
        instruction_of = insn; pc_of = pc; op1_of = o1; op2_of = o2;
        immx_of = im; ctrl_of = ct; isBranchTaken = bt; rst = rst_v;
        #1;
        act_stall = stall_if;
        exp_stall = m_lu(insn, bt, rst_v);
        @(posedge clk);
        if (rst_v) begin
            m_insn = 32'h6800_0000; m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0;
            m_ctrl = 0; m_valid = 0; m_cnt = 0; m_in_stall = 0;
        end else begin
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            if (bt || exp_stall) begin
                m_insn = 32'h6800_0000; m_ctrl = 0; m_valid = 0;
            end else begin
                m_insn = insn; m_pc = pc; m_op1 = o1; m_op2 = o2; m_imm = im;
                m_ctrl = ct; m_valid = 1;
            end
            m_in_stall = exp_stall;
        end
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " insn_e"}, instruction_e, m_insn);
        chk({tag, " valid_e"}, valid_e, m_valid);
        chk({tag, " ctrl_e"}, ctrl_e, m_ctrl);
        chk({tag, " pc_e"}, pc_e, m_pc);
        chk({tag, " op1_e"}, op1_e, m_op1);
        chk({tag, " op2_e"}, op2_e, m_op2);
        chk({tag, " immx_e"}, immx_e, m_imm);
        chk({tag, " stall_count"}, stall_count, m_cnt);
        chk({tag, " state"}, fsm_state, m_in_stall);
    endtask

    typedef struct {
        logic [31:0] insn;
        bit          bt;
        bit          exp_stall;
        logic [31:0] exp_insn;
        bit          exp_valid;
        int          exp_cnt;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [31:0] ld3, add523, addi, st3, ld15, ret_i, nopr3, pc, prev_pc;
        logic [21:0] ct;
        bit a_st, e_st;

        ld3    = enc(14, 1, 3, 1, 18'd4);
        add523 = enc(0, 0, 5, 3, {4'd2, 14'd0});
        addi   = enc(0, 1, 5, 2, {4'd3, 14'd0});
        st3    = enc(15, 1, 3, 4, 18'd0);
        ld15   = enc(14, 1, 15, 1, 18'd0);
        ret_i  = enc(20, 0, 0, 0, 18'd0);
        nopr3  = enc(13, 0, 0, 3, 18'd0);

        vt[0]  = '{ld3,    0, 0, ld3,          1, 0};
        vt[1]  = '{add523, 0, 1, 32'h6800_0000, 0, 1};
        vt[2]  = '{add523, 0, 0, add523,       1, 1};
        vt[3]  = '{ld3,    0, 0, ld3,          1, 1};
        vt[4]  = '{addi,   0, 0, addi,         1, 1};
        vt[5]  = '{ld3,    0, 0, ld3,          1, 1};
        vt[6]  = '{st3,    0, 1, 32'h6800_0000, 0, 2};
        vt[7]  = '{st3,    0, 0, st3,          1, 2};
        vt[8]  = '{ld3,    0, 0, ld3,          1, 2};
        vt[9]  = '{add523, 1, 0, 32'h6800_0000, 0, 2};
        vt[10] = '{add523, 0, 0, add523,       1, 2};
        vt[11] = '{ld15,   0, 0, ld15,         1, 2};
        vt[12] = '{ret_i,  0, 1, 32'h6800_0000, 0, 3};
        vt[13] = '{ret_i,  0, 0, ret_i,        1, 3};
        vt[14] = '{ld3,    0, 0, ld3,          1, 3};
        vt[15] = '{nopr3,  0, 0, nopr3,        1, 3};

        // Reset for two cycles
        @(negedge clk);
        step(ld3, 0, 0, 0, 0, 0, 0, 1, a_st, e_st);
        chk("reset stall_if c1", a_st, 0);
        step(add523, 0, 0, 0, 0, 0, 0, 1, a_st, e_st);
        chk("reset stall_if c2", a_st, 0);
        chk("reset insn_e", instruction_e, 32'h6800_0000);
        chk("reset valid_e", valid_e, 0);
        chk("reset ctrl_e", ctrl_e, 0);
        chk("reset pc_e", pc_e, 0);
        chk("reset stall_count", stall_count, 0);
        chk("reset state", fsm_state, ST_RUN);

        // Directed vector table
        prev_pc = 0;
        for (int i = 0; i < 16; i++) begin
            pc = 32'h100 + 32'(i * 4);
            ct = 22'h20_0000 | 22'(i + 1);
            step(vt[i].insn, pc, 32'(i * 3 + 1), 32'(i * 5 + 2), 32'(i + 7), ct,
                 vt[i].bt, 0, a_st, e_st);
            chk($sformatf("vec%0d stall_if", i), a_st, vt[i].exp_stall);
            chk($sformatf("vec%0d insn_e", i), instruction_e, vt[i].exp_insn);
            chk($sformatf("vec%0d valid_e", i), valid_e, vt[i].exp_valid);
            chk($sformatf("vec%0d ctrl_e", i), ctrl_e, vt[i].exp_valid ? ct : 22'd0);
            if (vt[i].exp_valid) prev_pc = pc;
            chk($sformatf("vec%0d pc_e", i), pc_e, prev_pc);
            chk($sformatf("vec%0d stall_count", i), stall_count, vt[i].exp_cnt);
        end

        // Reset asserted while in STALL
        step(ld3, 32'h400, 1, 2, 3, 22'h1, 0, 0, a_st, e_st);
        step(add523, 32'h404, 4, 5, 6, 22'h2, 0, 0, a_st, e_st);
        chk("midstall stall_if", a_st, 1);
        chk("midstall state", fsm_state, ST_STALL);
        step(add523, 32'h404, 4, 5, 6, 22'h2, 0, 1, a_st, e_st);
        chk("midstall rst stall_if", a_st, 0);
        chk("midstall rst state", fsm_state, ST_RUN);
        chk("midstall rst valid_e", valid_e, 0);
        chk("midstall rst stall_count", stall_count, 0);
        chk("midstall rst insn_e", instruction_e, 32'h6800_0000);
        step(add523, 32'h404, 4, 5, 6, 22'h2, 0, 0, a_st, e_st);
        chk("midstall reenter stall_if", a_st, 0);
        chk("midstall reenter insn_e", instruction_e, add523);
        chk("midstall reenter valid_e", valid_e, 1);
        chk("midstall reenter pc_e", pc_e, 32'h404);

        // Counter saturation: 2^CNT_W + 5 interlocks
        for (int n = 0; n < (1 << TB_CNT_W) + 5; n++) begin
            step(ld3, 32'h500, 0, 0, 0, 22'h3, 0, 0, a_st, e_st);
            step(add523, 32'h504, 0, 0, 0, 22'h4, 0, 0, a_st, e_st);
        end
        chk("sat last stall_if", a_st, 1);
        chk("sat stall_count", stall_count, {TB_CNT_W{1'b1}});

        // Randomized traffic against the model
        begin
            logic [31:0] r_insn, r_pc, r_o1, r_o2, r_im;
            logic [21:0] r_ct;
            bit r_bt, r_rst, hold;
            hold = 0;
            r_insn = 0; r_pc = 0; r_o1 = 0; r_o2 = 0; r_im = 0; r_ct = 0;
            for (int c = 0; c < 400; c++) begin
                if (!hold) begin
                    int op, rd;
                    op = ($urandom_range(0, 2) == 0) ? 14 : int'($urandom_range(0, 20));
                    rd = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 3));
                    r_insn = enc(op, 1'($urandom_range(0, 1)), rd, int'($urandom_range(0, 3)),
                                 {4'($urandom_range(0, 3)), 14'($urandom)});
                    r_pc = $urandom; r_o1 = $urandom; r_o2 = $urandom; r_im = $urandom;
                    r_ct = 22'($urandom);
                end
                r_bt  = ($urandom_range(0, 7) == 0);
                r_rst = ($urandom_range(0, 49) == 0);
                step(r_insn, r_pc, r_o1, r_o2, r_im, r_ct, r_bt, r_rst, a_st, e_st);
                chk($sformatf("rnd%0d stall_if", c), a_st, e_st);
                chk_model($sformatf("rnd%0d", c));
                hold = e_st;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
